baccarat_statemachine: RTL and testbench

//  Baccarat dealing sequencer for the card game datapath. Clocked by the slow (button) clock.

---
 rtl/baccarat_pkg.sv | 21 ++
 rtl/dealer_draw_rule.sv | 25 ++
 rtl/baccarat_statemachine.sv | 91 +++++++++
 tb/tb_baccarat_statemachine.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/baccarat_pkg.sv
// rtl/baccarat_pkg.sv - state codes, natural threshold and card-value helper for the baccarat sequencer
package baccarat_pkg;

  typedef enum logic [2:0] {
    PC1 = 3'd0,
    DC1 = 3'd1,
    PC2 = 3'd2,
    DC2 = 3'd3,
    PC3 = 3'd4,
    DC3 = 3'd5,
    WIN = 3'd6
  } state_t;

  localparam logic [3:0] NATURAL_MIN = 4'd8;

  // Ace..nine count face value; ten, face cards and the empty code 0 count zero.
  function automatic logic [3:0] card_value(input logic [3:0] code);
    card_value = (code >= 4'd1 && code <= 4'd9) ? code : 4'd0;
  endfunction

endpackage

// File: rtl/dealer_draw_rule.sv
// rtl/dealer_draw_rule.sv - banker third-card decision after the player has drawn
module dealer_draw_rule
  import baccarat_pkg::*;
(
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       draw
);

  logic [3:0] v;

  always_comb begin
    v    = card_value(pcard3);
    draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (v != 4'd8);
      4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
      default:          draw = 1'b0;
    endcase
  end

endmodule

// File: rtl/baccarat_statemachine.sv
// rtl/baccarat_statemachine.sv - baccarat dealing sequencer; DEBUG_STATE_EN exposes state_dbg
module baccarat_statemachine
  import baccarat_pkg::*;
(
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light
`ifdef DEBUG_STATE_EN
  ,
  output logic [2:0] state_dbg
`endif
);

  state_t state;
  state_t next_state;
  logic   banker_draw;

  dealer_draw_rule u_draw_rule (
    .dscore (dscore),
    .pcard3 (pcard3),
    .draw   (banker_draw)
  );

  always_ff @(posedge slow_clock) begin
    if (resetb) state <= PC1;
    else        state <= next_state;
  end

  always_comb begin
    next_state       = state;
    load_pcard1      = 1'b0;
    load_pcard2      = 1'b0;
    load_pcard3      = 1'b0;
    load_dcard1      = 1'b0;
    load_dcard2      = 1'b0;
    load_dcard3      = 1'b0;
    player_win_light = 1'b0;
    dealer_win_light = 1'b0;
    case (state)
      PC1: begin
        load_pcard1 = 1'b1;
        next_state  = DC1;
      end
      DC1: begin
        load_dcard1 = 1'b1;
        next_state  = PC2;
      end
      PC2: begin
        load_pcard2 = 1'b1;
        next_state  = DC2;
      end
      DC2: begin
        load_dcard2 = 1'b1;
        if (pscore >= NATURAL_MIN || dscore >= NATURAL_MIN) next_state = WIN;
        else if (pscore <= 4'd5)                            next_state = PC3;
        else if (dscore <= 4'd5)                            next_state = DC3;
        else                                                next_state = WIN;
      end
      PC3: begin
        load_pcard3 = 1'b1;
        next_state  = banker_draw ? DC3 : WIN;
      end
      DC3: begin
        load_dcard3 = 1'b1;
        next_state  = WIN;
      end
      WIN: begin
        // Tie lights both.
        player_win_light = (pscore >= dscore);
        dealer_win_light = (dscore >= pscore);
        next_state       = WIN;
      end
      default: next_state = PC1;
    endcase
  end

`ifdef DEBUG_STATE_EN
  assign state_dbg = state;
`endif

endmodule

// File: tb/tb_baccarat_statemachine.sv
// tb/tb_baccarat_statemachine.sv - scoreboard bench for baccarat_statemachine against a hand-level model
module tb_baccarat_statemachine;

  logic       clk = 1'b0;
  logic       resetb = 1'b1;
  logic [3:0] pscore = 4'd0;
  logic [3:0] dscore = 4'd0;
  logic [3:0] pcard3 = 4'd0;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light, dealer_win_light;
`ifdef DEBUG_STATE_EN
  logic [2:0] state_dbg;
`endif

  baccarat_statemachine dut (
    .slow_clock       (clk),
    .resetb           (resetb),
    .pscore           (pscore),
    .dscore           (dscore),
    .pcard3           (pcard3),
    .load_pcard1      (load_pcard1),
    .load_pcard2      (load_pcard2),
    .load_pcard3      (load_pcard3),
    .load_dcard1      (load_dcard1),
    .load_dcard2      (load_dcard2),
    .load_dcard3      (load_dcard3),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light)
`ifdef DEBUG_STATE_EN
    ,
    .state_dbg        (state_dbg)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    logic [5:0] loads;  // {d3,p3,d2,p2,d1,p1}
    logic       pw;
    logic       dw;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Hand model: step k (0..5) is the k-th card dealt in order p1,d1,p2,d2,p3,d3; 6 = hand settled.
  int         step = 0;
  bit         model_valid = 0;
  logic       cur_r = 1'b1;
  logic [3:0] cur_p = 4'd0, cur_d = 4'd0, cur_c = 4'd0;

  function automatic int val_of(input logic [3:0] code);
    int c = int'(code);
    return (c >= 1 && c <= 9) ? c : 0;
  endfunction

  function automatic bit banker_draws_after_player(input int d, input int v);
    if (d <= 2) return 1;
    if (d == 3) return v != 8;
    if (d >= 7) return 0;
    return (v >= 2 * (d - 3)) && (v <= 7);
  endfunction

  function automatic int advance(input int s, input int p, input int d, input int v);
    if (s < 3) return s + 1;
    if (s == 3) begin
      if (p >= 8 || d >= 8) return 6;
      if (p <= 5) return 4;
      return (d <= 5) ? 5 : 6;
    end
    if (s == 4) return banker_draws_after_player(d, v) ? 5 : 6;
    return 6;
  endfunction

  task automatic cycle(input logic r, input int p, input int d, input int c);
    exp_t e;
    @(posedge clk);
    #2;
    if (cur_r) begin
      step        = 0;
      model_valid = 1;
    end else if (model_valid) begin
      step = advance(step, int'(cur_p), int'(cur_d), val_of(cur_c));
    end
    cur_r  = r;
    cur_p  = 4'(p);
    cur_d  = 4'(d);
    cur_c  = 4'(c);
    resetb = cur_r;
    pscore = cur_p;
    dscore = cur_d;
    pcard3 = cur_c;
    if (model_valid) begin
      e.st    = 3'(step);
      e.loads = (step < 6) ? (6'b1 << step) : 6'b0;
      e.pw    = (step == 6) && (p >= d);
      e.dw    = (step == 6) && (d >= p);
      exp_q.push_back(e);
    end
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, want);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("state", 8'(dut.state), 8'(e.st));
      check("loads", 8'({load_dcard3, load_pcard3, load_dcard2, load_pcard2, load_dcard1, load_pcard1}), 8'(e.loads));
      check("player_win_light", 8'(player_win_light), 8'(e.pw));
      check("dealer_win_light", 8'(dealer_win_light), 8'(e.dw));
`ifdef DEBUG_STATE_EN
      check("state_dbg", 8'(state_dbg), 8'(e.st));
`endif
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t got=running expected=finished", $time);
    $fatal(1, "timeout");
  end

  initial begin
    // Natural for player, then hold in WIN
    cycle(1, 8, 5, 0);
    repeat (6) cycle(0, 8, 5, 0);
    // Natural for banker
    cycle(1, 5, 8, 0);
    repeat (5) cycle(0, 5, 8, 0);
    // Player draws, banker on 7 stands; score change shown in WIN
    cycle(1, 3, 7, 0);
    repeat (4) cycle(0, 3, 7, 0);
    repeat (2) cycle(0, 6, 7, 0);
    cycle(0, 9, 7, 0);
    // Banker 6 draws on pcard3=6, then scores change
    cycle(1, 4, 6, 0);
    repeat (4) cycle(0, 4, 6, 6);
    cycle(0, 0, 6, 6);
    repeat (2) cycle(0, 0, 4, 6);
    // Player stands on 7, banker 5 draws
    cycle(1, 7, 5, 0);
    repeat (4) cycle(0, 7, 5, 0);
    repeat (2) cycle(0, 7, 6, 0);
    // Tie through DC3, then reset mid-hand at DC3
    cycle(1, 1, 1, 6);
    repeat (6) cycle(0, 1, 1, 6);
    cycle(1, 1, 1, 6);
    repeat (5) cycle(0, 1, 1, 6);
    cycle(1, 1, 1, 6);
    repeat (2) cycle(0, 2, 2, 0);
    // Randomised hands with occasional mid-hand resets
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
            $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 13));
    end
    repeat (3) @(posedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain got=%0d expected=0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
